// File: rtl/uart_tx_scheduler_pkg.sv
// Shared state encoding, tag constants and pointer helper for the UART TX scheduler.
package uart_tx_scheduler_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_TAG  = 3'd1;
  localparam logic [2:0] ST_SEND = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_END  = 3'd4;

  localparam logic [7:0] TAG_BASE_DEFAULT = 8'hA0;

  function automatic int next_ptr(input int cur, input int num);
    return (cur + 32'sd1) % num;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_picker.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_picker #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               hit,
  output logic [IDX_W-1:0]   idx
);

  // scan requesters starting at ptr, keep the first one found
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!hit && req[(int'(ptr) + i) % NUM_SRC]) begin
        hit = 1'b1;
        idx = IDX_W'((int'(ptr) + i) % NUM_SRC);
      end else begin
        hit = hit;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin per-packet sharing of one UART transmitter among NUM_SRC byte sources.
// Optional macro UART_SRC_TAG_EN prefixes every packet with a tag byte TAG_BASE|grant_id.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int                   NUM_SRC     = 4,
  parameter int                   DATA_BITS   = 8,
  parameter int                   STALL_LIMIT = 1023,
  parameter int                   STALL_BITS  = 10,
  parameter logic [DATA_BITS-1:0] TAG_BASE    = DATA_BITS'(TAG_BASE_DEFAULT)
) (
  input  logic                           clk_50MHz,
  input  logic                           reset,
  input  logic [NUM_SRC-1:0]             src_req,
  input  logic [NUM_SRC*DATA_BITS-1:0]   src_data,
  input  logic [NUM_SRC-1:0]             src_last,
  output logic [NUM_SRC-1:0]             src_ack,
  output logic                           tx_start,
  output logic [DATA_BITS-1:0]           tx_data,
  input  logic                           tx_busy,
  input  logic                           tx_done_tick,
  output logic                           grant_valid,
  output logic [$clog2(NUM_SRC)-1:0]     grant_id,
  output logic                           stall_abort
);

  localparam int IDX_W = $clog2(NUM_SRC);

  state_t                state_r;
  logic [IDX_W-1:0]      rr_ptr_r;
  logic                  last_r;
  logic [STALL_BITS-1:0] stall_cnt_r;

  logic                  hit_s;
  logic [IDX_W-1:0]      idx_s;
  logic                  sel_req_s;
  logic                  sel_last_s;
  logic [DATA_BITS-1:0]  sel_data_s;
  logic [IDX_W-1:0]      next_ptr_s;

  rr_picker #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req (src_req),
    .ptr (rr_ptr_r),
    .hit (hit_s),
    .idx (idx_s)
  );

  // view of the granted source's request, data and end-of-packet flag
  always_comb begin
    sel_req_s  = src_req[grant_id];
    sel_last_s = src_last[grant_id];
    sel_data_s = src_data[grant_id*DATA_BITS +: DATA_BITS];
    next_ptr_s = IDX_W'(next_ptr(int'(grant_id), NUM_SRC));
  end

  // packet FSM: grant, byte hand-off, wait for stop bit, stall release
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      last_r      <= 1'b0;
      stall_cnt_r <= '0;
      src_ack     <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      stall_abort <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      src_ack     <= '0;
      stall_abort <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          stall_cnt_r <= '0;
          if (hit_s) begin
            grant_id    <= idx_s;
            grant_valid <= 1'b1;
`ifdef UART_SRC_TAG_EN
            state_r     <= ST_TAG;
`else
            state_r     <= ST_SEND;
`endif
          end
        end
        ST_TAG: begin
          if (!tx_busy) begin
            tx_data  <= TAG_BASE | DATA_BITS'(grant_id);
            tx_start <= 1'b1;
            last_r   <= 1'b0;
            state_r  <= ST_WAIT;
          end
        end
        ST_SEND: begin
          if (sel_req_s) begin
            if (!tx_busy) begin
              tx_data     <= sel_data_s;
              last_r      <= sel_last_s;
              tx_start    <= 1'b1;
              src_ack     <= {{(NUM_SRC-1){1'b0}}, 1'b1} << grant_id;
              stall_cnt_r <= '0;
              state_r     <= ST_WAIT;
            end
          end else if (stall_cnt_r == STALL_BITS'(STALL_LIMIT - 1)) begin
            // source went silent mid-packet: give the line to the next requester
            stall_abort <= 1'b1;
            grant_valid <= 1'b0;
            rr_ptr_r    <= next_ptr_s;
            state_r     <= ST_END;
          end else begin
            stall_cnt_r <= stall_cnt_r + STALL_BITS'(1);
          end
        end
        ST_WAIT: begin
          if (tx_done_tick) begin
            if (last_r) begin
              grant_valid <= 1'b0;
              rr_ptr_r    <= next_ptr_s;
              state_r     <= ST_END;
            end else begin
              stall_cnt_r <= '0;
              state_r     <= ST_SEND;
            end
          end
        end
        ST_END: begin
          state_r <= ST_IDLE;
        end
        default: begin
          grant_valid <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler with a behavioural UART and source FIFOs.
module tb_uart_tx_scheduler;

  localparam int NS = 4;
  localparam int DB = 8;
  localparam int SL = 20;
  localparam int SB = 5;
`ifdef UART_SRC_TAG_EN
  localparam int TAG_EN = 1;
`else
  localparam int TAG_EN = 0;
`endif

  logic          clk_50MHz = 1'b0;
  logic          reset;
  logic [NS-1:0] src_req;
  logic [NS*DB-1:0] src_data;
  logic [NS-1:0] src_last;
  logic [NS-1:0] src_ack;
  logic          tx_start;
  logic [DB-1:0] tx_data;
  logic          tx_busy;
  logic          tx_done_tick;
  logic          grant_valid;
  logic [1:0]    grant_id;
  logic          stall_abort;

  uart_tx_scheduler #(
    .NUM_SRC(NS), .DATA_BITS(DB), .STALL_LIMIT(SL), .STALL_BITS(SB)
  ) dut (
    .clk_50MHz(clk_50MHz), .reset(reset), .src_req(src_req), .src_data(src_data),
    .src_last(src_last), .src_ack(src_ack), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done_tick(tx_done_tick), .grant_valid(grant_valid),
    .grant_id(grant_id), .stall_abort(stall_abort)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  logic [8:0] srcq [NS][$];
  logic [9:0] sb [$];
  int n_checks, n_pass, n_start, n_abort, cyc, start_cyc, abort_delay, busy_cnt;
  int ack_cnt [NS];
  logic [7:0] held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic put(input int src, input logic [7:0] d, input logic last, input bit first, input bit expect_it);
    srcq[src].push_back({last, d});
    if (expect_it) begin
      if (first && TAG_EN != 0) sb.push_back({2'(src), 8'hA0 | 8'(src)});
      sb.push_back({2'(src), d});
    end
  endtask

  function automatic bit all_idle();
    bit q_empty = 1'b1;
    for (int n = 0; n < NS; n++) if (srcq[n].size() != 0) q_empty = 1'b0;
    return q_empty && !grant_valid && !tx_busy && sb.size() == 0;
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    bit ok = 1'b0;
    while (k < budget && !ok) begin
      @(negedge clk_50MHz);
      k++;
      ok = all_idle();
    end
    chk({tag, "_idle"}, 32'(ok), 32'd1);
  endtask

  task automatic refresh_src();
    logic [8:0] e;
    for (int n = 0; n < NS; n++) begin
      if (srcq[n].size() != 0) begin
        e = srcq[n][0];
        src_req[n] = 1'b1;
        src_data[n*DB +: DB] = e[7:0];
        src_last[n] = e[8];
      end else begin
        src_req[n] = 1'b0;
        src_data[n*DB +: DB] = 8'h00;
        src_last[n] = 1'b0;
      end
    end
  endtask

  // checks every DUT output event, models the UART and pops acked source bytes
  task automatic monitor();
    logic [9:0] e;
    forever begin
      @(negedge clk_50MHz);
      cyc++;
      if (reset) begin
        tx_busy = 1'b0;
        tx_done_tick = 1'b0;
        busy_cnt = 0;
        for (int n = 0; n < NS; n++) srcq[n].delete();
      end else begin
        if (tx_start) begin
          n_start++;
          start_cyc = cyc;
          chk("start_while_busy", 32'(tx_busy), 32'd0);
          chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("line_owner", 32'(grant_id), 32'(e[9:8]));
            chk("line_byte", 32'(tx_data), 32'(e[7:0]));
          end
          held = tx_data;
        end else if (tx_busy) begin
          chk("tx_data_hold", 32'(tx_data), 32'(held));
        end
        if (src_ack != '0) begin
          chk("ack_onehot", 32'($onehot(src_ack)), 32'd1);
          chk("ack_owner", 32'(src_ack), 32'(4'b0001 << grant_id));
          chk("ack_with_grant", 32'(grant_valid), 32'd1);
          for (int n = 0; n < NS; n++) begin
            if (src_ack[n]) begin
              ack_cnt[n]++;
              if (srcq[n].size() != 0) void'(srcq[n].pop_front());
            end
          end
        end
        if (stall_abort) begin
          n_abort++;
          abort_delay = cyc - start_cyc;
          chk("abort_drops_grant", 32'(grant_valid), 32'd0);
        end
        tx_done_tick = 1'b0;
        if (tx_start) begin
          tx_busy = 1'b1;
          busy_cnt = 4;
        end else if (tx_busy) begin
          busy_cnt--;
          if (busy_cnt == 0) begin
            tx_busy = 1'b0;
            tx_done_tick = 1'b1;
          end
        end
      end
      refresh_src();
    end
  endtask

  initial begin
    int s, a0, a1, a2, a3, k;
    bit ok;
    reset = 1'b1;
    tx_busy = 1'b0;
    tx_done_tick = 1'b0;
    src_req = '0;
    src_data = '0;
    src_last = '0;
    n_checks = 0; n_pass = 0; n_start = 0; n_abort = 0; cyc = 0; start_cyc = 0; abort_delay = 0;
    for (int n = 0; n < NS; n++) ack_cnt[n] = 0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk_50MHz);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_src_ack", 32'(src_ack), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_grant_valid", 32'(grant_valid), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_stall_abort", 32'(stall_abort), 32'd0);
    @(posedge clk_50MHz); #1;
    reset = 1'b0;

    // 1: single 3-byte packet from src0
    @(posedge clk_50MHz); #1;
    s = n_start; a0 = ack_cnt[0];
    put(0, 8'h11, 1'b0, 1'b1, 1'b1);
    put(0, 8'h22, 1'b0, 1'b0, 1'b1);
    put(0, 8'h33, 1'b1, 1'b0, 1'b1);
    wait_idle("t1", 200);
    chk("t1_starts", 32'(n_start - s), 32'(3 + TAG_EN));
    chk("t1_ack0", 32'(ack_cnt[0] - a0), 32'd3);
    chk("t1_grant_low", 32'(grant_valid), 32'd0);

    // 2: src1 and src2 together, then a src2/src3 tie with the pointer at 3
    @(posedge clk_50MHz); #1;
    a1 = ack_cnt[1]; a2 = ack_cnt[2];
    put(1, 8'hB1, 1'b0, 1'b1, 1'b1);
    put(1, 8'hB2, 1'b1, 1'b0, 1'b1);
    put(2, 8'hC1, 1'b1, 1'b1, 1'b1);
    wait_idle("t2a", 300);
    chk("t2a_ack1", 32'(ack_cnt[1] - a1), 32'd2);
    chk("t2a_ack2", 32'(ack_cnt[2] - a2), 32'd1);
    @(posedge clk_50MHz); #1;
    put(3, 8'hD3, 1'b1, 1'b1, 1'b1);
    put(2, 8'hD2, 1'b1, 1'b1, 1'b1);
    wait_idle("t2b", 300);

    // 3: src0 arrives while src3 owns the line
    @(posedge clk_50MHz); #1;
    a0 = ack_cnt[0]; a3 = ack_cnt[3];
    put(3, 8'hE1, 1'b0, 1'b1, 1'b1);
    put(3, 8'hE2, 1'b0, 1'b0, 1'b1);
    put(3, 8'hE3, 1'b1, 1'b0, 1'b1);
    k = 0; ok = 1'b0;
    while (k < 50 && !ok) begin
      @(negedge clk_50MHz);
      k++;
      ok = grant_valid && grant_id == 2'd3;
    end
    chk("t3_grant3", 32'(ok), 32'd1);
    @(posedge clk_50MHz); #1;
    put(0, 8'hF0, 1'b1, 1'b1, 1'b1);
    wait_idle("t3", 300);
    chk("t3_ack3", 32'(ack_cnt[3] - a3), 32'd3);
    chk("t3_ack0", 32'(ack_cnt[0] - a0), 32'd1);

    // 4: src1 goes silent after an unterminated byte, src2 waits behind it
    @(posedge clk_50MHz); #1;
    s = n_abort;
    put(1, 8'h44, 1'b0, 1'b1, 1'b1);
    put(2, 8'h55, 1'b1, 1'b1, 1'b1);
    wait_idle("t4", 400);
    chk("t4_abort_count", 32'(n_abort - s), 32'd1);
    chk("t4_abort_not_early", 32'(abort_delay >= SL), 32'd1);
    chk("t4_abort_not_late", 32'(abort_delay <= SL + 12), 32'd1);

    // 5: single-byte packet from src2 (tag byte first when enabled)
    @(posedge clk_50MHz); #1;
    s = n_start; a2 = ack_cnt[2];
    put(2, 8'h5A, 1'b1, 1'b1, 1'b1);
    wait_idle("t5", 200);
    chk("t5_starts", 32'(n_start - s), 32'(1 + TAG_EN));
    chk("t5_ack2", 32'(ack_cnt[2] - a2), 32'd1);

    // 6: reset while the first byte is on the line
    @(posedge clk_50MHz); #1;
    s = n_start;
    put(0, 8'h61, 1'b0, 1'b1, 1'b1);
    put(0, 8'h62, 1'b1, 1'b0, 1'b0);
    k = 0;
    while (k < 100 && n_start < s + 1 + TAG_EN) begin
      @(negedge clk_50MHz);
      k++;
    end
    chk("t6_reach_wait", 32'(n_start - s), 32'(1 + TAG_EN));
    repeat (2) @(negedge clk_50MHz);
    #2 reset = 1'b1;
    #1;
    chk("t6_tx_start", 32'(tx_start), 32'd0);
    chk("t6_src_ack", 32'(src_ack), 32'd0);
    chk("t6_tx_data", 32'(tx_data), 32'd0);
    chk("t6_grant_valid", 32'(grant_valid), 32'd0);
    chk("t6_grant_id", 32'(grant_id), 32'd0);
    chk("t6_stall_abort", 32'(stall_abort), 32'd0);
    repeat (2) @(negedge clk_50MHz);
    @(posedge clk_50MHz); #1;
    reset = 1'b0;
    s = n_start;
    repeat (30) @(negedge clk_50MHz);
    chk("t6_quiet_after_reset", 32'(n_start - s), 32'd0);
    @(posedge clk_50MHz); #1;
    put(1, 8'h81, 1'b1, 1'b1, 1'b1);
    put(2, 8'h82, 1'b1, 1'b1, 1'b1);
    wait_idle("t6", 300);
    chk("total_aborts", 32'(n_abort), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
